product_accumulator: RTL and testbench

- Downstream stage of the 16x16 unsigned array multiplier.
- Consumes the 32-bit product stream through a valid/ready handshake and accumulates the products into a wide sum.
- Emits one dot-product result per vector, where a vector is terminated by in_last or by reaching MAX_LEN terms.
- Used to build MAC / FIR datapaths on top of the combinational multiplier.

---
 rtl/product_accumulator_pkg.sv | 23 ++
 rtl/product_accumulator_acc_adder.sv | 29 ++
 rtl/product_accumulator.sv | 129 ++++++++++++
 tb/tb_product_accumulator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM encoding, default
// widths and the saturation mode selected by PRODUCT_ACCUMULATOR_SATURATE_EN.
package product_accumulator_pkg;

    localparam int unsigned PROD_W_DEF  = 32;
    localparam int unsigned ACC_W_DEF   = 40;
    localparam int unsigned MAX_LEN_DEF = 256;
    localparam int unsigned CNT_W_DEF   = $clog2(MAX_LEN_DEF) + 1;

    // ACCUM collects beats; HOLD presents a finished result until taken.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // On overflow the sum clamps to all-ones (2^ACC_W-1) when enabled.
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Combinational accumulator adder: acc + zero-extended product, with carry
// out and an optional clamp to all-ones (PRODUCT_ACCUMULATOR_SATURATE_EN).
module product_accumulator_acc_adder
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum_c,
    output logic              carry_c
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] full_sum;

    // Widen by one bit so the carry out of ACC_W is visible.
    always_comb begin
        full_sum = {1'b0, acc} + SUM_W'(addend);
        carry_c  = full_sum[ACC_W];
        sum_c    = full_sum[ACC_W-1:0];
        if (SAT_EN && carry_c) begin
            sum_c = '1;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Product accumulator: sums the multiplier's product stream into one result
// per vector (ended by in_last or MAX_LEN terms), valid/ready on both sides.
// Saturating arithmetic is selected by PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    state_e             state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q,  out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q,   out_ovf_d;

    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic               accept;

    product_accumulator_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc_adder (
        .acc     (acc_q),
        .addend  (in_data),
        .sum_c   (sum),
        .carry_c (carry)
    );

    // Ready only while collecting, not clearing, and out of reset.
    assign in_ready = (state_q == ACCUM) && !clr && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state, accumulation and result capture.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ACCUM: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    if (in_last || (cnt_q == LAST_IDX)) begin
                        out_data_d  = sum;
                        out_count_d = cnt_q + CNT_W'(1);
                        out_ovf_d   = ovf_q | carry;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | carry;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: default 40-bit instance plus a 33-bit
// instance sharing the same stimulus for overflow behaviour.
module tb_product_accumulator;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf;
    logic [39:0] out_data;
    logic [8:0]  out_count;
    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [32:0] out_data_s;
    logic [8:0]  out_count_s;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    product_accumulator #(.ACC_W(33)) dut_s (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_count(out_count_s), .out_ovf(out_ovf_s)
    );

    // Reference: a vector's result is the true sum of its terms, reduced by
    // wrap or clamp; overflow means the true sum does not fit in w bits.
    function automatic logic [63:0] ref_data(input logic [63:0] total, input int unsigned w);
        logic [63:0] lim;
        lim = 64'd1 << w;
        if (total < lim) return total;
        return SAT ? (lim - 64'd1) : (total & (lim - 64'd1));
    endfunction

    function automatic logic ref_ovf(input logic [63:0] total, input int unsigned w);
        return total >= (64'd1 << w);
    endfunction

    // Present one beat and wait (bounded) until it is accepted.
    task automatic send_beat(input logic [31:0] d, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_beat: in_ready never rose, got %b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_last = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        vectors++; if (out_data !== 40'h0) begin miscompares++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        vectors++; if (out_count !== 9'd0) begin miscompares++; $display("FAIL reset_out_count: got %0d required 0", out_count); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf: got %b required 0", out_ovf); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_basic();
        time t0;
        out_ready = 1'b1;
        t0 = $time;
        send_beat(32'h0000_0006, 1'b0);
        send_beat(32'hFFFE_0001, 1'b0);
        send_beat(32'h0000_0010, 1'b1);
        vectors++; if ($time - t0 != 30) begin miscompares++; $display("FAIL basic_throughput: got %0t required 30", $time - t0); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid: got %b required 1", out_valid); end
        vectors++; if (out_data !== 40'h00_FFFE_0017) begin miscompares++; $display("FAIL basic_out_data: got %h required 00fffe0017", out_data); end
        vectors++; if (out_count !== 9'd3) begin miscompares++; $display("FAIL basic_out_count: got %0d required 3", out_count); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_out_ovf: got %b required 0", out_ovf); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_one_cycle: got %b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(32'h0000_1234, 1'b1);
        in_valid = 1'b1; in_data = 32'h0000_0055; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready); end
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_out_valid[%0d]: got %b required 1", i, out_valid); end
            vectors++; if (out_data !== 40'h1234 || out_count !== 9'd1) begin
                miscompares++; $display("FAIL hold_outputs[%0d]: got %h/%0d required 1234/1", i, out_data, out_count);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_out_valid: got %b required 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== 40'h55 || out_count !== 9'd1) begin
            miscompares++; $display("FAIL next_beat_after_release: got v=%b %h/%0d required v=1 55/1", out_valid, out_data, out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_len();
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) send_beat(32'hFFFF_FFFF, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL max_len_early: got %b required 0", out_valid); end
        send_beat(32'hFFFF_FFFF, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL max_len_valid: got %b required 1", out_valid); end
        vectors++; if (out_count !== 9'd256) begin miscompares++; $display("FAIL max_len_count: got %0d required 256", out_count); end
        vectors++; if (out_data !== 40'hFF_FFFF_FF00) begin miscompares++; $display("FAIL max_len_data: got %h required ffffffff00", out_data); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL max_len_ovf: got %b required 0", out_ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [32:0] exp_s;
        exp_s = SAT ? 33'h1_FFFF_FFFF : 33'h0_FFFF_FFFD;
        out_ready = 1'b1;
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b1);
        vectors++; if (out_data_s !== exp_s) begin miscompares++; $display("FAIL ovf33_data: got %h required %h", out_data_s, exp_s); end
        vectors++; if (out_ovf_s !== 1'b1) begin miscompares++; $display("FAIL ovf33_flag: got %b required 1", out_ovf_s); end
        vectors++; if (out_count_s !== 9'd3) begin miscompares++; $display("FAIL ovf33_count: got %0d required 3", out_count_s); end
        vectors++; if (out_data !== 40'h02_FFFF_FFFD || out_ovf !== 1'b0) begin
            miscompares++; $display("FAIL ovf40_no_overflow: got %h ovf=%b required 02fffffffd ovf=0", out_data, out_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        send_beat(32'd5, 1'b0);
        send_beat(32'd5, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 32'd7; in_last = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL clr_in_ready: got %b required 0", in_ready); end
        @(posedge clk); #1;
        clr = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_beat_taken: got %b required 0", out_valid); end
        send_beat(32'd7, 1'b1);
        vectors++; if (out_valid !== 1'b1 || out_data !== 40'd7 || out_count !== 9'd1 || out_ovf !== 1'b0) begin
            miscompares++; $display("FAIL clr_result: got v=%b %h/%0d ovf=%b required v=1 7/1 ovf=0", out_valid, out_data, out_count, out_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_hold();
        out_ready = 1'b0;
        send_beat(32'd9, 1'b1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rh_hold: got %b required 1", out_valid); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rh_valid_drop: got %b required 0", out_valid); end
        vectors++; if (out_data !== 40'h0) begin miscompares++; $display("FAIL rh_data_clear: got %h required 0", out_data); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rh_in_ready: got %b required 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(32'd1, i == 3);
        vectors++; if (out_valid !== 1'b1 || out_data !== 40'd4 || out_count !== 9'd4) begin
            miscompares++; $display("FAIL rh_fresh_vector: got v=%b %h/%0d required v=1 4/4", out_valid, out_data, out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        localparam int NVEC = 40;
        logic [63:0] exp_tot[$];
        int          exp_len[$];
        out_ready = 1'b0;
        fork
            begin
                for (int v = 0; v < NVEC; v++) begin
                    int unsigned len;
                    logic [63:0] total;
                    len   = $urandom_range(1, 7);
                    total = 64'd0;
                    for (int b = 0; b < int'(len); b++) begin
                        logic [31:0] d;
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        d = $urandom;
                        total += 64'(d);
                        send_beat(d, b == int'(len) - 1);
                    end
                    exp_tot.push_back(total);
                    exp_len.push_back(int'(len));
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                while (got < NVEC && cyc < 4000) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        vectors++;
                        if (exp_tot.size() == 0) begin
                            miscompares++; $display("FAIL rand_unexpected_result: got %h required none", out_data);
                        end else begin
                            logic [63:0] t;
                            int          n;
                            t = exp_tot.pop_front();
                            n = exp_len.pop_front();
                            if (out_data !== ref_data(t, 40)[39:0] || out_ovf !== ref_ovf(t, 40) || out_count !== 9'(n)) begin
                                miscompares++; $display("FAIL rand40[%0d]: got %h/%0d ovf=%b required %h/%0d ovf=%b",
                                    got, out_data, out_count, out_ovf, ref_data(t, 40)[39:0], n, ref_ovf(t, 40));
                            end
                            vectors++;
                            if (out_data_s !== ref_data(t, 33)[32:0] || out_ovf_s !== ref_ovf(t, 33) || out_count_s !== 9'(n)) begin
                                miscompares++; $display("FAIL rand33[%0d]: got %h/%0d ovf=%b required %h/%0d ovf=%b",
                                    got, out_data_s, out_count_s, out_ovf_s, ref_data(t, 33)[32:0], n, ref_ovf(t, 33));
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                vectors++;
                if (got != NVEC) begin
                    miscompares++; $display("FAIL rand_timeout: got %0d results required %0d", got, NVEC);
                end
            end
        join
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_max_len();
        test_overflow();
        test_clr();
        test_reset_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
